// File: rtl/eeprom_bist_pkg.sv
// Shared types and helpers for the EEPROM BIST sequencer.
package eeprom_bist_pkg;

    typedef enum logic [7:0] {
        ST_IDLE     = 8'b0000_0001,
        ST_WR_REQ   = 8'b0000_0010,
        ST_WR_WAIT  = 8'b0000_0100,
        ST_WR_DELAY = 8'b0000_1000,
        ST_RD_REQ   = 8'b0001_0000,
        ST_RD_WAIT  = 8'b0010_0000,
        ST_CHECK    = 8'b0100_0000,
        ST_FINISH   = 8'b1000_0000
    } state_t;

    localparam logic [1:0] RETRY_LIMIT = 2'd3;

    function automatic logic [7:0] pattern(input logic [7:0] addr_lo, input logic [7:0] seed);
        return addr_lo ^ seed;
    endfunction

endpackage

// File: rtl/bist_delay_cnt.sv
// Loadable down-counter; tc is high in the last cycle of a loaded count (minimum one cycle).
module bist_delay_cnt #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt;
    logic         run;

    assign tc = run && (cnt <= ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            cnt <= load_val;
            run <= 1'b1;
        end else if (tc) begin
            run <= 1'b0;
        end else if (run) begin
            cnt <= cnt - ONE;
        end
    end
endmodule

// File: rtl/eeprom_bist_ctrl.sv
// EEPROM BIST sequencer: writes a seeded pattern over an address range, reads it back and compares.
// Optional macro BIST_NACK_RETRY_EN reissues NACKed transactions up to RETRY_LIMIT times.
import eeprom_bist_pkg::*;

module eeprom_bist_ctrl #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter logic [15:0] BYTE_NUM    = 16'd256,
    parameter logic        ADDR16      = 1'b1,
    parameter logic [19:0] WR_WAIT_CYC = 20'd5000,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        i2c_exec,
    output logic        bit_ctrl,
    output logic        i2c_rh_wl,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data_w,
    input  logic [7:0]  i2c_data_r,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic        nack_err
);
    state_t      state, state_nxt;
    logic [15:0] idx, idx_nxt, err_nxt, addr_nxt, req_addr;
    logic [7:0]  data_w_nxt, rd_data, rd_data_nxt, chk_lo;
    logic        rh_wl_nxt, busy_nxt, pass_nxt, nack_nxt, wr_retry, wr_retry_nxt;
    logic        done_q, done_rise, last, do_retry, dly_load, dly_tc;

    assign bit_ctrl  = ADDR16;
    assign i2c_exec  = (state == ST_WR_REQ) || (state == ST_RD_REQ);
    assign done      = (state == ST_FINISH);
    assign done_rise = i2c_done && !done_q;
    assign last      = (idx == BYTE_NUM - 16'd1);
    assign chk_lo    = BASE_ADDR[7:0] + idx[7:0];

`ifdef BIST_NACK_RETRY_EN
    logic [1:0] retry_cnt;

    assign do_retry = i2c_ack && (retry_cnt != RETRY_LIMIT);

    // Cleared whenever a byte completes without a retry, so each byte gets a fresh budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt <= '0;
        end else if (done_rise && (state == ST_WR_WAIT || state == ST_RD_WAIT)) begin
            retry_cnt <= do_retry ? retry_cnt + 2'd1 : 2'd0;
        end
    end
`else
    assign do_retry = 1'b0;
`endif

    bist_delay_cnt #(.W(20)) u_dly (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dly_load),
        .load_val (WR_WAIT_CYC),
        .tc       (dly_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            err_cnt    <= '0;
            nack_err   <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b0;
            rd_data    <= '0;
            i2c_addr   <= '0;
            i2c_data_w <= '0;
            i2c_rh_wl  <= 1'b0;
            wr_retry   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            err_cnt    <= err_nxt;
            nack_err   <= nack_nxt;
            pass       <= pass_nxt;
            busy       <= busy_nxt;
            rd_data    <= rd_data_nxt;
            i2c_addr   <= addr_nxt;
            i2c_data_w <= data_w_nxt;
            i2c_rh_wl  <= rh_wl_nxt;
            wr_retry   <= wr_retry_nxt;
            done_q     <= i2c_done;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        err_nxt      = err_cnt;
        nack_nxt     = nack_err;
        pass_nxt     = pass;
        busy_nxt     = busy;
        rd_data_nxt  = rd_data;
        addr_nxt     = i2c_addr;
        data_w_nxt   = i2c_data_w;
        rh_wl_nxt    = i2c_rh_wl;
        wr_retry_nxt = wr_retry;
        dly_load     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    idx_nxt   = '0;
                    err_nxt   = '0;
                    nack_nxt  = 1'b0;
                    pass_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_WR_REQ;
                end
            end
            ST_WR_REQ: state_nxt = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (done_rise) begin
                    dly_load     = 1'b1;
                    wr_retry_nxt = do_retry;
                    if (!do_retry) nack_nxt = nack_err | i2c_ack;
                    state_nxt    = ST_WR_DELAY;
                end
            end
            ST_WR_DELAY: begin
                if (dly_tc) begin
                    if (wr_retry) begin
                        state_nxt = ST_WR_REQ;
                    end else if (last) begin
                        idx_nxt   = '0;
                        state_nxt = ST_RD_REQ;
                    end else begin
                        idx_nxt   = idx + 16'd1;
                        state_nxt = ST_WR_REQ;
                    end
                end
            end
            ST_RD_REQ: state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (done_rise) begin
                    if (do_retry) begin
                        state_nxt = ST_RD_REQ;
                    end else begin
                        rd_data_nxt = i2c_data_r;
                        nack_nxt    = nack_err | i2c_ack;
                        state_nxt   = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if ((rd_data != pattern(chk_lo, SEED)) && (err_cnt != 16'hFFFF))
                    err_nxt = err_cnt + 16'd1;
                if (last) begin
                    state_nxt = ST_FINISH;
                end else begin
                    idx_nxt   = idx + 16'd1;
                    state_nxt = ST_RD_REQ;
                end
            end
            ST_FINISH: begin
                busy_nxt  = 1'b0;
                pass_nxt  = (err_cnt == 16'd0) && !nack_err;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Request fields are loaded on entry to a request state and then held through done.
        req_addr = BASE_ADDR + idx_nxt;
        if (state_nxt == ST_WR_REQ || state_nxt == ST_RD_REQ) begin
            addr_nxt  = req_addr;
            rh_wl_nxt = (state_nxt == ST_RD_REQ);
            if (state_nxt == ST_WR_REQ) data_w_nxt = pattern(req_addr[7:0], SEED);
        end
    end
endmodule

// File: tb/tb_eeprom_bist_ctrl.sv
// Self-checking bench for eeprom_bist_ctrl: table scenarios, randomized scenarios, reset and wrap cases.
module tb_eeprom_bist_ctrl;
    localparam logic [15:0] BASE0 = 16'h0010;
    localparam logic [15:0] NUM0  = 16'd4;
    localparam logic [19:0] WR0   = 20'd10;
    localparam logic [7:0]  SEED  = 8'hA5;
`ifdef BIST_NACK_RETRY_EN
    localparam int ATTEMPTS = 4;
`else
    localparam int ATTEMPTS = 1;
`endif

    typedef struct {
        logic [15:0] addr;
        logic        rh;
        logic [7:0]  data;
        int          ecyc;
    } txn_t;

    typedef struct {
        logic        cor_en;
        logic [15:0] cor_addr;
        logic        nack_en;
        logic [15:0] nack_addr;
        int          hold;
        logic [15:0] exp_err;
        logic        exp_nack;
        logic        exp_pass;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    logic        start0, exec0, bitc0, rh0, drv_done0, ack0, busy0, bdone0, pass0, nack0;
    logic [15:0] addr0, err0;
    logic [7:0]  dw0, dr0;
    logic        start1, exec1, bitc1, rh1, drv_done1, ack1, busy1, bdone1, pass1, nack1;
    logic [15:0] addr1, err1;
    logic [7:0]  dw1, dr1;

    eeprom_bist_ctrl #(.BASE_ADDR(BASE0), .BYTE_NUM(NUM0), .ADDR16(1'b1),
                       .WR_WAIT_CYC(WR0), .SEED(SEED)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .i2c_exec(exec0), .bit_ctrl(bitc0),
        .i2c_rh_wl(rh0), .i2c_addr(addr0), .i2c_data_w(dw0), .i2c_data_r(dr0),
        .i2c_done(drv_done0), .i2c_ack(ack0), .busy(busy0), .done(bdone0), .pass(pass0),
        .err_cnt(err0), .nack_err(nack0));

    eeprom_bist_ctrl #(.BASE_ADDR(16'hFFFF), .BYTE_NUM(16'd2), .ADDR16(1'b1),
                       .WR_WAIT_CYC(20'd3), .SEED(SEED)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .i2c_exec(exec1), .bit_ctrl(bitc1),
        .i2c_rh_wl(rh1), .i2c_addr(addr1), .i2c_data_w(dw1), .i2c_data_r(dr1),
        .i2c_done(drv_done1), .i2c_ack(ack1), .busy(busy1), .done(bdone1), .pass(pass1),
        .err_cnt(err1), .nack_err(nack1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // EEPROM/driver model for instance 0
    logic [7:0]  mem0 [0:65535];
    txn_t        req_q[$];
    txn_t        log_q[$];
    int          dcyc_q[$];
    int          hold_cur = 1;
    logic        cor_en = 1'b0, nack_en = 1'b0;
    logic [15:0] cor_addr = '0, nack_addr = '0;

    always @(negedge clk) begin
        if (exec0 === 1'b1) begin
            txn_t t;
            t.addr = addr0; t.rh = rh0; t.data = dw0; t.ecyc = cyc;
            req_q.push_back(t);
            log_q.push_back(t);
        end
    end

    initial begin : resp0
        txn_t rt;
        drv_done0 = 1'b0; ack0 = 1'b0; dr0 = 8'h00;
        forever begin
            @(negedge clk);
            if (req_q.size() > 0) begin
                rt = req_q.pop_front();
                repeat ($urandom_range(4, 1)) @(negedge clk);
                if (rst_n) begin
                    chk("hold_addr", addr0, rt.addr);
                    chk("hold_rh", rh0, rt.rh);
                    if (!rt.rh) chk("hold_dw", dw0, rt.data);
                end
                if (rt.rh) dr0 = (cor_en && rt.addr == cor_addr) ? 8'h00 : mem0[rt.addr];
                else mem0[rt.addr] = rt.data;
                ack0 = !rt.rh && nack_en && (rt.addr == nack_addr);
                drv_done0 = 1'b1;
                dcyc_q.push_back(cyc);
                repeat (hold_cur) @(negedge clk);
                drv_done0 = 1'b0;
                ack0 = 1'b0;
            end
        end
    end

    // Simple always-ACK model for instance 1
    logic [7:0] mem1 [0:65535];
    txn_t       log1[$];
    initial begin : resp1
        txn_t t;
        drv_done1 = 1'b0; ack1 = 1'b0; dr1 = 8'h00;
        forever begin
            @(negedge clk);
            if (exec1 === 1'b1) begin
                t.addr = addr1; t.rh = rh1; t.data = dw1; t.ecyc = cyc;
                log1.push_back(t);
                if (!rh1) mem1[addr1] = dw1;
                repeat (2) @(negedge clk);
                dr1 = mem1[t.addr];
                drv_done1 = 1'b1;
                @(negedge clk);
                drv_done1 = 1'b0;
            end
        end
    end

    // Reference model: expected transaction list and result flags from the test rules
    txn_t        exp_q[$];
    logic [15:0] m_err;
    logic        m_nack, m_pass;

    task automatic build_exp();
        txn_t t;
        logic [15:0] a;
        exp_q.delete();
        m_err = '0;
        m_nack = 1'b0;
        for (int i = 0; i < int'(NUM0); i++) begin
            a = BASE0 + 16'(i);
            t.addr = a; t.rh = 1'b0; t.data = a[7:0] ^ SEED; t.ecyc = 0;
            if (nack_en && a == nack_addr) begin
                m_nack = 1'b1;
                repeat (ATTEMPTS) exp_q.push_back(t);
            end else begin
                exp_q.push_back(t);
            end
        end
        for (int i = 0; i < int'(NUM0); i++) begin
            a = BASE0 + 16'(i);
            t.addr = a; t.rh = 1'b1; t.data = a[7:0] ^ SEED; t.ecyc = 0;
            exp_q.push_back(t);
            if (cor_en && a == cor_addr && t.data != 8'h00) m_err = m_err + 16'd1;
        end
        m_pass = (m_err == 16'd0) && !m_nack;
    endtask

    task automatic run_scn(input string nm, input logic use_model, input logic [15:0] e_err,
                           input logic e_nack, input logic e_pass);
        logic seen;
        int   n;
        log_q.delete();
        dcyc_q.delete();
        build_exp();
        if (use_model) begin
            e_err = m_err; e_nack = m_nack; e_pass = m_pass;
        end
        for (int a = 0; a < int'(NUM0); a++) mem0[BASE0 + 16'(a)] = 8'h00;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        chk($sformatf("%s_busy", nm), busy0, 1'b1);
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4000 && !seen; k++) begin
            @(negedge clk);
            if (bdone0) seen = 1'b1;
        end
        chk($sformatf("%s_done_seen", nm), seen, 1'b1);
        @(negedge clk);
        chk($sformatf("%s_done_pulse", nm), bdone0, 1'b0);
        chk($sformatf("%s_busy_end", nm), busy0, 1'b0);
        chk($sformatf("%s_pass", nm), pass0, e_pass);
        chk($sformatf("%s_err_cnt", nm), err0, e_err);
        chk($sformatf("%s_nack_err", nm), nack0, e_nack);
        chk($sformatf("%s_txn_count", nm), log_q.size(), exp_q.size());
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_txn%0d_addr", nm, i), log_q[i].addr, exp_q[i].addr);
            chk($sformatf("%s_txn%0d_rh", nm, i), log_q[i].rh, exp_q[i].rh);
            if (!exp_q[i].rh) chk($sformatf("%s_txn%0d_data", nm, i), log_q[i].data, exp_q[i].data);
        end
        for (int i = 0; i + 1 < log_q.size() && i < dcyc_q.size(); i++) begin
            if (!log_q[i].rh)
                chk($sformatf("%s_gap%0d_ok", nm, i),
                    (log_q[i+1].ecyc - dcyc_q[i]) >= int'(WR0) + 1, 1'b1);
        end
    endtask

    vec_t vecs [5];

    initial begin : wdog
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic        seen;
        logic [15:0] ea [4];
        logic        er [4];
        logic [7:0]  ed [2];
        vecs[0] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1, 16'd0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 16'h0012, 1'b0, 16'h0000, 1, 16'd1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 16'h0011, 1, 16'd0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 3, 16'd0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 16'h0010, 1'b1, 16'h0013, 2, 16'd1, 1'b1, 1'b0};
        ea = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        er = '{1'b0, 1'b0, 1'b1, 1'b1};
        ed = '{8'h5A, 8'hA5};
        start0 = 1'b0;
        start1 = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_exec", exec0, 1'b0);
        chk("rst_rh", rh0, 1'b0);
        chk("rst_addr", addr0, 16'h0000);
        chk("rst_dw", dw0, 8'h00);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", bdone0, 1'b0);
        chk("rst_pass", pass0, 1'b0);
        chk("rst_err", err0, 16'h0000);
        chk("rst_nack", nack0, 1'b0);
        chk("rst_bit_ctrl", bitc0, 1'b1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // address wrap instance
        log1.delete();
        start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(negedge clk);
            if (bdone1) seen = 1'b1;
        end
        chk("wrap_done_seen", seen, 1'b1);
        @(negedge clk);
        chk("wrap_pass", pass1, 1'b1);
        chk("wrap_err", err1, 16'h0000);
        chk("wrap_nack", nack1, 1'b0);
        chk("wrap_txn_count", log1.size(), 4);
        for (int i = 0; i < 4 && i < log1.size(); i++) begin
            chk($sformatf("wrap_txn%0d_addr", i), log1[i].addr, ea[i]);
            chk($sformatf("wrap_txn%0d_rh", i), log1[i].rh, er[i]);
            if (i < 2) chk($sformatf("wrap_txn%0d_data", i), log1[i].data, ed[i]);
        end

        for (int v = 0; v < 5; v++) begin
            cor_en = vecs[v].cor_en; cor_addr = vecs[v].cor_addr;
            nack_en = vecs[v].nack_en; nack_addr = vecs[v].nack_addr;
            hold_cur = vecs[v].hold;
            run_scn($sformatf("vec%0d", v), 1'b0, vecs[v].exp_err, vecs[v].exp_nack, vecs[v].exp_pass);
        end

        for (int r = 0; r < 6; r++) begin
            cor_en = 1'($urandom_range(1, 0));
            cor_addr = BASE0 + 16'($urandom_range(3, 0));
            nack_en = 1'($urandom_range(1, 0));
            nack_addr = BASE0 + 16'($urandom_range(3, 0));
            hold_cur = $urandom_range(3, 1);
            run_scn($sformatf("rnd%0d", r), 1'b1, 16'd0, 1'b0, 1'b0);
        end

        // reset while waiting on the read of the third byte
        cor_en = 1'b0; nack_en = 1'b0; hold_cur = 1;
        log_q.delete(); dcyc_q.delete();
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4000 && !seen; k++) begin
            @(negedge clk); #1;
            if (log_q.size() >= 7) seen = 1'b1;
        end
        chk("mid_rst_reached", seen, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_exec", exec0, 1'b0);
        chk("mid_rst_rh", rh0, 1'b0);
        chk("mid_rst_addr", addr0, 16'h0000);
        chk("mid_rst_dw", dw0, 8'h00);
        chk("mid_rst_busy", busy0, 1'b0);
        chk("mid_rst_pass", pass0, 1'b0);
        chk("mid_rst_err", err0, 16'h0000);
        chk("mid_rst_nack", nack0, 1'b0);
        chk("mid_rst_bit_ctrl", bitc0, 1'b1);
        repeat (12) @(negedge clk);
        req_q.delete(); log_q.delete(); dcyc_q.delete();
        rst_n = 1'b1;
        run_scn("post_rst", 1'b0, 16'd0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/eeprom_bist_ctrl.md
Name: eeprom_bist_ctrl

Overview:
- Sequencer for the single-byte I2C EEPROM driver: drives its exec/address/data/direction inputs and consumes its done/ack/read-data outputs.
- On `start`, writes a deterministic pattern to a contiguous EEPROM range, one byte per transaction, waiting the device write-cycle time after each write.
- Then reads the range back and compares; reports pass/fail, mismatch count and NACK status.
- Clocked by the driver's `drv_clk`, so handshakes are cycle-aligned with the driver FSM.

Parameters:
- BASE_ADDR, 16'h0000, first EEPROM address tested.
- BYTE_NUM, 16'd256, number of bytes tested (legal range 1..65535).
- ADDR16, 1'b1, drives `bit_ctrl`: 1 = 16-bit word address, 0 = 8-bit.
- WR_WAIT_CYC, 20'd5000, idle clk cycles after each write's done before the next transaction (tWR).
- SEED, 8'hA5, pattern seed.

Ports:
- clk  input  1  controller clock (driver `drv_clk`)
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level/pulse; sampled only in IDLE
- i2c_exec  output  1  one-cycle transaction request to the driver
- bit_ctrl  output  1  constant ADDR16
- i2c_rh_wl  output  1  0 = write, 1 = read
- i2c_addr  output  16  current EEPROM address
- i2c_data_w  output  8  write data
- i2c_data_r  input  8  driver read data, valid when done rises
- i2c_done  input  1  driver completion, high for ≥1 cycle
- i2c_ack  input  1  1 = NACK seen in the last transaction
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse at end of test
- pass  output  1  result, held until the next start
- err_cnt  output  16  mismatch count, saturating at 16'hFFFF
- nack_err  output  1  sticky NACK flag, cleared on start

Behaviour:
- Reset values: all outputs 0 except `bit_ctrl` = ADDR16. Counters and FSM return to IDLE.
- FSM states: IDLE, WR_REQ, WR_WAIT, WR_DELAY, RD_REQ, RD_WAIT, CHECK, FINISH.
- IDLE: on `start`=1:
  - idx←0, err_cnt←0, nack_err←0, pass←0, busy←1
  - next state WR_REQ
- WR_REQ:
  - i2c_exec=1 for exactly one cycle, i2c_rh_wl=0
  - i2c_addr = BASE_ADDR+idx (16-bit wrap)
  - i2c_data_w = (BASE_ADDR+idx)[7:0] ^ SEED
  - next state WR_WAIT
- WR_WAIT: wait for the rising edge of i2c_done (registered prev value).
  - Level-high done is not reused; a stale high at entry is ignored.
  - On the edge: nack_err |= i2c_ack; go to WR_DELAY with delay counter cleared.
- WR_DELAY: count WR_WAIT_CYC cycles.
  - If idx==BYTE_NUM-1: idx←0, go to RD_REQ.
  - Otherwise idx←idx+1, go to WR_REQ.
- RD_REQ: same as WR_REQ but i2c_rh_wl=1; i2c_data_w unchanged.
- RD_WAIT: on the done rising edge, capture i2c_data_r, OR i2c_ack into nack_err, go to CHECK.
- CHECK: one cycle.
  - If captured ≠ expected pattern, err_cnt increments (saturating).
  - If idx==BYTE_NUM-1 go to FINISH; else idx+1, go to RD_REQ (no delay for reads).
- FINISH: done=1 for one cycle, busy←0, pass←(err_cnt==0 && !nack_err), return to IDLE.
- Addr, rh_wl and data_w are held stable from exec through done.
- `start` during busy is ignored.
- Reset mid-test: immediate return to IDLE; the driver is reset by the same rst_n.
- Latency per write ≈ driver transaction + 1 + WR_WAIT_CYC cycles; per read ≈ transaction + 2.

Optional Feature:
- Macro BIST_NACK_RETRY_EN.
- Defined: a transaction completing with i2c_ack=1 is reissued (back to WR_REQ or RD_REQ, same idx) up to 3 retries. A write retry waits WR_WAIT_CYC first (ACK polling). nack_err is set only when all retries fail. A 2-bit retry counter is reset per byte.
- Undefined: no retry; NACK sets nack_err and the sequence proceeds.

Decomposition:
- Shared package `eeprom_bist_pkg`:
  - state encoding localparams (one-hot 8-bit, matching the driver style)
  - pattern function addr[7:0]^seed
  - retry limit constant 3
- Sub-module `bist_delay_cnt`: loadable down-counter with a terminal-count pulse, used for WR_DELAY.

Test Plan:
- BYTE_NUM=4, BASE_ADDR=16'h0010, ACKing EEPROM model, WR_WAIT_CYC=10 → 4 writes to 0x10..0x13 of 0xB5,0xB4,0xB7,0xB6; ≥10 idle cycles between each write's done and the next exec; then 4 reads; done pulse, pass=1, err_cnt=0.
- Model corrupts read of 0x12 (returns 0x00) → pass=0, err_cnt=1, nack_err=0.
- Model NACKs the write to 0x11 every time, macro off → nack_err=1, pass=0, all 4 bytes still processed. Macro on → exactly 4 transactions to 0x11 before proceeding.
- i2c_done held high 3 cycles → exactly one transaction counted per exec, idx advances by 1.
- rst_n low during RD_WAIT of byte 2 → all outputs at reset values asynchronously; a new start restarts from BASE_ADDR.
- BASE_ADDR=16'hFFFF, BYTE_NUM=2 → addresses 0xFFFF then 0x0000; patterns 0x5A, 0xA5.
